// File: rtl/scl_gen_param.sv
// I3C SDR SCL generator with runtime-programmable push-pull / open-drain low and high periods.
// Optional completed-cycle counter output enabled by defining SCL_GEN_CYCLE_CNT_EN.
module scl_gen_param #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             i_sdr_ctrl_clk,
  input  logic             i_sdr_ctrl_rst_n,
  input  logic             i_scl_gen_pp_od,
  input  logic             i_scl_gen_stall,
  input  logic             i_sdr_ctrl_scl_idle,
  input  logic             i_timer_cas,
  input  logic [CNT_W-1:0] i_cfg_pp_low,
  input  logic [CNT_W-1:0] i_cfg_pp_high,
  input  logic [CNT_W-1:0] i_cfg_od_low,
  input  logic [CNT_W-1:0] i_cfg_od_high,
  output logic             o_scl,
  output logic             o_scl_pos_edge,
  output logic             o_scl_neg_edge,
  output logic             o_scl_busy
`ifdef SCL_GEN_CYCLE_CNT_EN
  ,
  output logic [CYC_W-1:0] o_scl_cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAS  = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } state_t;

  if (CNT_W < 1 || CYC_W < 1) begin : g_param_check
    $error("scl_gen_param: CNT_W and CYC_W must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] high_len;
  logic             low_done;
  logic             high_done;
  logic             to_idle;

  // A programmed period of zero behaves as one clock, so SCL never drops below a 2-clock period.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] p);
    return (p == '0) ? CNT_W'(1) : p;
  endfunction

  // NOTE: every always_comb output gets a value on every path; a missing branch would infer a latch.
  always_comb begin
    low_len   = eff_len(i_scl_gen_pp_od ? i_cfg_pp_low  : i_cfg_od_low);
    high_len  = eff_len(i_scl_gen_pp_od ? i_cfg_pp_high : i_cfg_od_high);
    low_done  = (state == LOW)  && (cnt == phase_len) && !i_scl_gen_stall;
    high_done = (state == HIGH) && (cnt == phase_len);
    to_idle   = ((state == CAS) || high_done) && i_sdr_ctrl_scl_idle;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_sdr_ctrl_clk) begin
    if (!i_sdr_ctrl_rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      phase_len      <= '0;
      o_scl          <= 1'b1;
      o_scl_pos_edge <= 1'b0;
      o_scl_neg_edge <= 1'b0;
      o_scl_busy     <= 1'b0;
    end else begin
      o_scl_pos_edge <= 1'b0;
      o_scl_neg_edge <= 1'b0;
      if (to_idle) begin
        state      <= IDLE;
        cnt        <= '0;
        o_scl      <= 1'b1;
        o_scl_busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!i_sdr_ctrl_scl_idle) begin
              state      <= CAS;
              o_scl_busy <= 1'b1;
            end
          end
          CAS: begin
            if (i_timer_cas) begin
              state          <= LOW;
              cnt            <= CNT_W'(1);
              phase_len      <= low_len;
              o_scl          <= 1'b0;
              o_scl_neg_edge <= 1'b1;
            end
          end
          LOW: begin
            // At terminal count a held stall leaves cnt parked on phase_len.
            if (low_done) begin
              state          <= HIGH;
              cnt            <= CNT_W'(1);
              phase_len      <= high_len;
              o_scl          <= 1'b1;
              o_scl_pos_edge <= 1'b1;
            end else if (cnt != phase_len) begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (high_done) begin
              state          <= LOW;
              cnt            <= CNT_W'(1);
              phase_len      <= low_len;
              o_scl          <= 1'b0;
              o_scl_neg_edge <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            cnt        <= '0;
            o_scl      <= 1'b1;
            o_scl_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SCL_GEN_CYCLE_CNT_EN
  always_ff @(posedge i_sdr_ctrl_clk) begin
    if (!i_sdr_ctrl_rst_n || to_idle) begin
      o_scl_cycle_cnt <= '0;
    end else if (low_done) begin
      o_scl_cycle_cnt <= o_scl_cycle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scl_gen_param.sv
// Self-checking bench for scl_gen_param: directed scenarios plus random traffic, all cycles
// compared against a countdown-based behavioural model of the SCL waveform.
module tb_scl_gen_param;

  localparam int TB_CYC_W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pp_od = 1'b1;
  logic       stall = 1'b0;
  logic       idle = 1'b1;
  logic       cas = 1'b0;
  logic [7:0] pp_low = 8'd2, pp_high = 8'd2, od_low = 8'd5, od_high = 8'd3;
  logic       scl, pos_edge, neg_edge, busy;
`ifdef SCL_GEN_CYCLE_CNT_EN
  logic [TB_CYC_W-1:0] cycle_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 waiting for tCAS, 2 low, 3 high; rem = cycles left in phase.
  int m_phase = 0;
  int m_rem   = 0;
  int m_cyc   = 0;
  bit m_scl   = 1'b1;
  bit m_prev  = 1'b1;
  bit m_pos   = 1'b0;
  bit m_neg   = 1'b0;
  bit m_in_reset = 1'b1;

  always #5 clk = ~clk;

`ifdef SCL_GEN_CYCLE_CNT_EN
  scl_gen_param #(.CNT_W(8), .CYC_W(TB_CYC_W)) dut (
`else
  scl_gen_param #(.CNT_W(8)) dut (
`endif
    .i_sdr_ctrl_clk      (clk),
    .i_sdr_ctrl_rst_n    (rst_n),
    .i_scl_gen_pp_od     (pp_od),
    .i_scl_gen_stall     (stall),
    .i_sdr_ctrl_scl_idle (idle),
    .i_timer_cas         (cas),
    .i_cfg_pp_low        (pp_low),
    .i_cfg_pp_high       (pp_high),
    .i_cfg_od_low        (od_low),
    .i_cfg_od_high       (od_high),
    .o_scl               (scl),
    .o_scl_pos_edge      (pos_edge),
    .o_scl_neg_edge      (neg_edge),
    .o_scl_busy          (busy)
`ifdef SCL_GEN_CYCLE_CNT_EN
    ,
    .o_scl_cycle_cnt     (cycle_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int len_of(input logic [7:0] p);
    return (p == 8'd0) ? 1 : int'(p);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_rem = 0; m_cyc = 0; m_in_reset = 1'b1;
    end else begin
      m_in_reset = 1'b0;
      case (m_phase)
        0: if (!idle) m_phase = 1;
        1: begin
          if (idle) begin
            m_phase = 0; m_cyc = 0;
          end else if (cas) begin
            m_phase = 2; m_rem = len_of(pp_od ? pp_low : od_low);
          end
        end
        2: begin
          if (m_rem > 1) m_rem--;
          else if (!stall) begin
            m_phase = 3; m_rem = len_of(pp_od ? pp_high : od_high);
            m_cyc = (m_cyc + 1) % (1 << TB_CYC_W);
          end
        end
        default: begin
          if (m_rem > 1) m_rem--;
          else if (idle) begin
            m_phase = 0; m_cyc = 0;
          end else begin
            m_phase = 2; m_rem = len_of(pp_od ? pp_low : od_low);
          end
        end
      endcase
    end
    m_scl  = (m_phase != 2);
    m_pos  = !m_in_reset && m_scl && !m_prev;
    m_neg  = !m_in_reset && !m_scl && m_prev;
    m_prev = m_scl;
  endtask

  // One clock: advance model at the edge, compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("scl", 32'(scl), 32'(m_scl));
    check("pos_edge", 32'(pos_edge), 32'(m_pos));
    check("neg_edge", 32'(neg_edge), 32'(m_neg));
    check("busy", 32'(busy), 32'(m_phase != 0));
    check("strobe_excl", 32'(pos_edge & neg_edge), 32'd0);
`ifdef SCL_GEN_CYCLE_CNT_EN
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
`endif
  endtask

  // sel: 0 = neg_edge, 1 = pos_edge, 2 = busy low
  task automatic wait_for(input int sel, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      hit = (sel == 0) ? neg_edge : (sel == 1) ? pos_edge : !busy;
    end
    n_checks++;
    assert (hit) else begin
      n_fail++;
      $error("FAIL %s: observed timeout expected event within 100 cycles", tag);
    end
  endtask

  // Counts cycles of the current SCL level, starting from 'already'; returns on first cycle of next level.
  task automatic run_phase(input int already, output int n);
    logic level = scl;
    n = already;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (scl !== level) break;
      n++;
    end
  endtask

  initial begin
    int l, h, npos;

    // Reset, then PP 2/2 traffic started by a tCAS pulse.
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    idle = 1'b0;
    repeat (2) tick();
    cas = 1'b1;
    tick();
    cas = 1'b0;
    check("pp_first_neg", 32'(neg_edge), 32'd1);
    run_phase(1, l);
    check("pp_low_len", l, 2);
    check("pp_pos_after_low", 32'(pos_edge), 32'd1);
    run_phase(1, h);
    check("pp_high_len", h, 2);

    // Reset from an active LOW phase.
    wait_for(0, "wait_neg_reset");
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pos", 32'(pos_edge), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    cas = 1'b1;
    tick();

    // OD 5/3, then switch to PP in the middle of a LOW phase.
    pp_od = 1'b0;
    wait_for(0, "wait_neg_od1");
    wait_for(0, "wait_neg_od2");
    run_phase(1, l);
    run_phase(1, h);
    check("od_period", l + h, 8);
    check("od_low_len", l, 5);
    tick();
    tick();
    pp_od = 1'b1;
    run_phase(3, l);
    check("switch_low_len", l, 5);
    run_phase(1, h);
    check("switch_high_len", h, 2);
    cas = 1'b0;

    // Stall for 6 clocks starting at the LOW entry cycle.
    wait_for(0, "wait_neg_stall");
    stall = 1'b1;
    repeat (6) tick();
    stall = 1'b0;
    run_phase(7, l);
    check("stall_low_len", l, 7);
    check("stall_release_pos", 32'(pos_edge), 32'd1);

    // Idle requested in the HIGH entry cycle: HIGH completes, then park.
    idle = 1'b1;
    tick();
    check("idle_mid_high_scl", 32'(scl), 32'd1);
    wait_for(2, "wait_idle");
    check("idle_scl", 32'(scl), 32'd1);
    repeat (5) tick();
    idle = 1'b0;
    tick();
    cas = 1'b1;
    wait_for(0, "restart_neg");

    // Zero configuration: period 2; count 17 pos edges from a fresh IDLE entry.
    idle = 1'b1;
    wait_for(2, "wait_idle_zero");
    {pp_low, pp_high, od_low, od_high} = '0;
    idle = 1'b0;
    wait_for(0, "zero_neg");
    run_phase(1, l);
    check("zero_low_len", l, 1);
    npos = 1;
    run_phase(1, h);
    check("zero_high_len", h, 1);
    for (int i = 0; i < 200 && npos < 17; i++) begin
      tick();
      if (pos_edge) npos++;
    end
    check("zero_pos_count", npos, 17);
`ifdef SCL_GEN_CYCLE_CNT_EN
    check("cycle_cnt_wrap", 32'(cycle_cnt), 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(3) == 0);
      cas   = ($urandom_range(2) == 0);
      if ($urandom_range(39) == 0) idle = ~idle;
      if ($urandom_range(24) == 0) pp_od = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) begin
        pp_low  = 8'($urandom_range(5));
        pp_high = 8'($urandom_range(5));
        od_low  = 8'($urandom_range(5));
        od_high = 8'($urandom_range(5));
      end
      rst_n = ($urandom_range(199) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scl_gen_param.md
Name: scl_gen_param

Overview:
- Parametrised successor to the fixed-ratio SDR SCL generator.
- Produces the I3C SCL waveform for the SDR controller.
- Low and high periods are runtime-programmable per drive mode: push-pull (PP) and open-drain (OD).
- Supports tCAS start handshake, low-phase stall extension and a clean return to idle-high; emits single-cycle edge strobes used by the SDR TX/RX datapaths.

Parameters:
CNT_W, 8, width of period configuration inputs and internal phase counter
CYC_W, 16, width of optional completed-cycle counter

Ports:
i_sdr_ctrl_clk  in  1  system clock; all logic on rising edge
i_sdr_ctrl_rst_n  in  1  synchronous active-low reset
i_scl_gen_pp_od  in  1  1 = push-pull timing, 0 = open-drain timing
i_scl_gen_stall  in  1  hold SCL low at end of LOW phase while 1
i_sdr_ctrl_scl_idle  in  1  request SCL to park high / stay idle
i_timer_cas  in  1  tCAS elapsed indication from timer
i_cfg_pp_low  in  CNT_W  PP low period in clocks
i_cfg_pp_high  in  CNT_W  PP high period in clocks
i_cfg_od_low  in  CNT_W  OD low period in clocks
i_cfg_od_high  in  CNT_W  OD high period in clocks
o_scl  out  1  registered SCL
o_scl_pos_edge  out  1  one-cycle pulse, first cycle o_scl=1 after low
o_scl_neg_edge  out  1  one-cycle pulse, first cycle o_scl=0 after high
o_scl_busy  out  1  1 in any state other than IDLE

Behaviour:
- Clock is i_sdr_ctrl_clk; reset is i_sdr_ctrl_rst_n, synchronous and active-low, sampled on the rising edge.
- Reset values: o_scl=1, both edge strobes=0, o_scl_busy=0, state=IDLE, counter=0. Reset mid-operation aborts immediately at the next edge and leaves no partial pulse.
- All outputs are registered. Edge strobes coincide with the o_scl transition cycle and never assert together.
- FSM states: IDLE, CAS, LOW, HIGH.
- IDLE: o_scl=1. If i_sdr_ctrl_scl_idle=0 → CAS.
- CAS: o_scl=1.
  - If idle=1 → IDLE.
  - Else if i_timer_cas=1 → LOW next cycle with o_scl=0, neg_edge=1, counter=1.
- Phase entry latch: on entering LOW or HIGH, the active mode and that phase's period are latched, selected by i_scl_gen_pp_od. Mode or config changes mid-phase take effect at the next phase entry.
- Zero period: a latched period of 0 is treated as 1. Minimum SCL period is 2 clocks.
- LOW: lasts latched_low cycles, including the entry cycle.
  - At counter==latched_low with stall=0 → HIGH: o_scl=1, pos_edge=1, counter=1.
  - With stall=1 the block stays LOW, the counter saturates, and no strobe is issued. Release gives pos_edge on the cycle after stall is sampled 0.
  - Stall during HIGH or CAS is ignored.
- HIGH: lasts latched_high cycles.
  - At terminal count, if idle=1 → IDLE: o_scl stays 1, no strobe.
  - Else → LOW with neg_edge=1.
- Idle asserted during LOW: the LOW phase and full HIGH phase complete, then IDLE. An SCL pulse is never truncated.
- Simultaneous terminal LOW + stall: stall wins.
- Simultaneous terminal HIGH + idle: idle wins.
- Counter arithmetic is CNT_W unsigned with no wrap; comparison is equality against the latched value.

Optional Feature:
- Macro: SCL_GEN_CYCLE_CNT_EN.
- Defined: adds output o_scl_cycle_cnt [CYC_W-1:0].
  - Increments on each pos_edge and wraps at 2^CYC_W.
  - Cleared to 0 on reset and on entry to IDLE.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks from an active LOW phase → o_scl=1, strobes=0, busy=0 on the first post-reset cycle.
- PP: low=2, high=2, idle=0, timer_cas pulse sampled at cycle N → neg_edge at N+1, pos_edge at N+3, neg_edge at N+5. Period 4, 50% duty.
- OD then switch: od_low=5, od_high=3 gives period 8. Set pp_od=1 (pp 2/2) mid-LOW → current LOW stays 5 cycles, the following HIGH is 2.
- Stall: pp 2/2, assert stall for 6 clocks starting in the LOW entry cycle → LOW lasts 7 cycles; pos_edge exactly 1 cycle after stall drops.
- Idle: assert idle mid-HIGH → HIGH completes, o_scl stays 1, no further neg_edge, busy=0. Deassert idle plus timer_cas → traffic restarts with neg_edge.
- Zero config: all cfg=0 → period 2 toggling. With SCL_GEN_CYCLE_CNT_EN and CYC_W=4, 17 pos_edges → o_scl_cycle_cnt=1.
